uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_tx_buffered.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and baud-divider helper.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

    // Serializer states; PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per line bit, truncating integer division.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous DEPTH x 8 byte FIFO with occupancy count and show-ahead head byte.
// Latency: a pushed byte is visible at pop_data one cycle after the accepting edge.
// Backpressure: push is ignored when full; pop is ignored when empty.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Fullness alone gates a push, so a same-cycle pop never opens extra room.
    assign do_push  = push && (level != FULL);
    assign do_pop   = pop && (level != '0);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because level qualifies them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; level tracks the difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN defined): byte FIFO feeding a serializer.
// Latency: start bit begins two edges after a byte enters an empty idle buffer; frames run back-to-back.
// Backpressure: s_ready drops while the FIFO holds DEPTH bytes; bytes offered then are dropped silently.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     tx_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     led_tx
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [7:0]    head;
    logic          bit_end;
    logic          pop;

    assign s_ready = (level < ($clog2(DEPTH) + 1)'(DEPTH));
    assign bit_end = (cnt == LAST);
    // Fetch the next byte from IDLE, or at the end of a stop bit so frames abut.
    assign pop     = (level != '0) && ((state == IDLE) || ((state == STOP) && bit_end));

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (pop),
        .pop_data  (head),
        .level     (level)
    );

    // Serializer FSM; line and status outputs are registered views of the current state,
    // so every line bit lags its state interval by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
            busy    <= 1'b0;
            led_tx  <= 1'b0;
        end else begin
            tx_done <= (state == STOP) && bit_end;
            busy    <= (state != IDLE) || (level != '0);
            led_tx  <= (state != IDLE);

            case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shreg[idx];
`ifdef UART_TX_PARITY_EN
                PARITY:  uart_tx <= ^shreg;
`endif
                default: uart_tx <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pop) begin
                        shreg <= head;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (pop) begin
                            shreg <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
